// File: rtl/cpu_mem_ctrl.sv
// cpu_mem_ctrl: single-outstanding line memory controller for a cache.
// Accepts one line read or write-back at a time and answers after a fixed
// latency with a one-cycle response pulse. The backing store is not reset.

`ifndef PHYSICAL_ADDR_WIDTH
`define PHYSICAL_ADDR_WIDTH 32
`endif

module cpu_mem_ctrl #(
  parameter int ADDR_WIDTH  = `PHYSICAL_ADDR_WIDTH,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH       = 256,
  parameter int MEM_LATENCY = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LINE_WIDTH-1:0] req_data,
  output logic                  available,
  output logic                  resp_valid,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [LINE_WIDTH-1:0] resp_data
);

  // Byte offset bits inside a line, then the index bits that pick an entry.
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BUSY    = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0]            r_state;
  logic [CNT_W-1:0]      r_count;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_data;
  logic [ADDR_WIDTH-1:0] r_respAddr;
  logic [LINE_WIDTH-1:0] r_respData;
  logic [LINE_WIDTH-1:0] r_store [DEPTH];

  logic [IDX_W-1:0]      w_index;
  logic                  w_access;

  // Upper address bits above the index simply alias onto the same entry.
  assign w_index  = r_addr[OFF+IDX_W-1:OFF];
  assign w_access = (r_state == BUSY) && (r_count == '0);

  assign available  = (r_state == IDLE);
  assign resp_valid = (r_state == RESPOND);
  assign resp_addr  = r_respAddr;
  assign resp_data  = r_respData;

  // Request FSM: latch on acceptance, count down the latency, then respond once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_respAddr <= '0;
      r_respData <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_state <= BUSY;
            r_count <= CNT_W'(MEM_LATENCY - 1);
            r_write <= req_write;
            r_addr  <= req_addr;
            r_data  <= req_data;
          end
        end
        BUSY: begin
          if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
          end else begin
            r_state    <= RESPOND;
            r_respAddr <= r_addr;
            r_respData <= r_write ? r_data : r_store[w_index];
          end
        end
        RESPOND: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Backing store write port; gated by the FSM so an aborted write never lands.
  always_ff @(posedge clock) begin
    if (w_access && r_write) begin
      r_store[w_index] <= r_data;
    end
  end

endmodule

// File: tb/tb_cpu_mem_ctrl.sv
// tb_cpu_mem_ctrl: randomized self-checking bench for cpu_mem_ctrl.
// A line-indexed associative array models the store; timing is checked
// against the fixed latency arithmetic.

module tb_cpu_mem_ctrl;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int DP = 256;
  localparam int LAT = 5;

  logic          clock;
  logic          reset;
  logic          reqValid, reqWrite;
  logic [AW-1:0] reqAddr;
  logic [LW-1:0] reqData;
  logic          available, respValid;
  logic [AW-1:0] respAddr;
  logic [LW-1:0] respData;

  logic          reqValid2, reqWrite2;
  logic [AW-1:0] reqAddr2;
  logic [LW-1:0] reqData2;
  logic          available2, respValid2;
  logic [AW-1:0] respAddr2;
  logic [LW-1:0] respData2;

  int nCompared;
  int nMismatched;

  logic [LW-1:0] modelMem [int];

  cpu_mem_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH(DP), .MEM_LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(reqValid), .req_write(reqWrite), .req_addr(reqAddr), .req_data(reqData),
    .available(available), .resp_valid(respValid), .resp_addr(respAddr), .resp_data(respData)
  );

  cpu_mem_ctrl #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .DEPTH(DP), .MEM_LATENCY(1)) dutFast (
    .clock(clock), .reset(reset),
    .req_valid(reqValid2), .req_write(reqWrite2), .req_addr(reqAddr2), .req_data(reqData2),
    .available(available2), .resp_valid(respValid2), .resp_addr(respAddr2), .resp_data(respData2)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Backstop so a stuck run still terminates loudly.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int lineIndex(input logic [AW-1:0] addr);
    return int'((longint'(addr) / (LW / 8)) % DP);
  endfunction

  function automatic logic [LW-1:0] randLine();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed,
                             input logic [LW-1:0] expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // One full transaction on the default-latency controller; optional
  // distractor requests are driven while it is busy and must be ignored.
  task automatic applyStimulus(input bit isWrite, input logic [AW-1:0] addr,
                               input logic [LW-1:0] data, input bit distract);
    int waitCycles;
    int latency;
    logic [LW-1:0] expData;
    bit known;
    waitCycles = 0;
    while (!available && waitCycles < 20) begin
      nextCycle();
      waitCycles++;
    end
    checkOutput("availBeforeReq", available, 1);
    reqValid = 1'b1;
    reqWrite = isWrite;
    reqAddr  = addr;
    reqData  = data;
    nextCycle();
    checkOutput("availAfterAccept", available, 0);
    if (!distract) reqValid = 1'b0;
    latency = 0;
    while (!respValid && latency < 20) begin
      if (distract) begin
        reqAddr  = addr ^ 32'h0000_0730;
        reqData  = randLine();
        reqWrite = $urandom_range(0, 1) == 1;
      end
      nextCycle();
      latency++;
    end
    reqValid = 1'b0;
    checkOutput("latency", latency, LAT);
    checkOutput("respAddr", respAddr, addr);
    known = 1'b1;
    if (isWrite) begin
      modelMem[lineIndex(addr)] = data;
      expData = data;
    end else if (modelMem.exists(lineIndex(addr))) begin
      expData = modelMem[lineIndex(addr)];
    end else begin
      expData = '0;
      known = 1'b0;
    end
    if (known) checkOutput("respData", respData, expData);
    nextCycle();
    checkOutput("singlePulse", respValid, 0);
    checkOutput("availAfterResp", available, 1);
    checkOutput("respAddrHeld", respAddr, addr);
  endtask

  initial begin
    logic [LW-1:0] oldLine;
    logic [AW-1:0] fastAddr [12];
    logic [LW-1:0] fastData [12];
    int pulses;
    nCompared   = 0;
    nMismatched = 0;
    reset     = 1'b0;
    reqValid  = 1'b0; reqWrite  = 1'b0; reqAddr  = '0; reqData  = '0;
    reqValid2 = 1'b0; reqWrite2 = 1'b0; reqAddr2 = '0; reqData2 = '0;

    // Reset values while reset is held low.
    nextCycle();
    nextCycle();
    checkOutput("rstAvail", available, 1);
    checkOutput("rstRespValid", respValid, 0);
    checkOutput("rstRespAddr", respAddr, 0);
    checkOutput("rstRespData", respData, 0);
    reset = 1'b1;

    // Reference write/read pair, accepted on the first edge after reset.
    applyStimulus(1'b1, 32'h40, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666, 1'b0);
    applyStimulus(1'b0, 32'h40, '0, 1'b0);
    checkOutput("readBack40", respData, 128'hA5A5_0000_1111_2222_3333_4444_5555_6666);

    // Index wrap and ignored offset bits.
    applyStimulus(1'b1, 32'h40 + DP * 16, 128'h1, 1'b0);
    applyStimulus(1'b0, 32'h4F, '0, 1'b0);
    checkOutput("aliasRead", respData, 128'h1);

    // Requests during BUSY are ignored.
    applyStimulus(1'b0, 32'h40, '0, 1'b1);

    // Abort a write by reset mid-operation.
    oldLine = randLine();
    applyStimulus(1'b1, 32'h80, oldLine, 1'b0);
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h80; reqData = ~oldLine;
    nextCycle();
    reqValid = 1'b0;
    checkOutput("abortAccepted", available, 0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("abortAvail", available, 1);
    checkOutput("abortRespValid", respValid, 0);
    checkOutput("abortRespData", respData, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if (respValid) pulses++;
    end
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nextCycle();
      if (respValid) pulses++;
    end
    checkOutput("abortNoResp", pulses, 0);
    applyStimulus(1'b0, 32'h80, '0, 1'b0);
    checkOutput("abortKeepsOld", respData, oldLine);

    // Randomized traffic over a few aliased lines.
    for (int t = 0; t < 25; t++) begin
      logic [AW-1:0] a;
      a = AW'(($urandom_range(0, 7) << 4) | $urandom_range(0, 15) | ($urandom_range(0, 3) << 12));
      applyStimulus($urandom_range(0, 1) == 1, a, randLine(), $urandom_range(0, 3) == 0);
    end

    // Latency-1 controller with req_valid held high: accept every 3 cycles.
    reset = 1'b0;
    nextCycle();
    reqValid2 = 1'b1;
    reqWrite2 = 1'b1;
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      fastAddr[k] = AW'($urandom);
      fastData[k] = randLine();
      reqAddr2 = fastAddr[k];
      reqData2 = fastData[k];
      nextCycle();
      if (respValid2) pulses++;
      checkOutput("fastAvail", available2, (k % 3 == 2) ? 1 : 0);
      checkOutput("fastResp", respValid2, (k % 3 == 1) ? 1 : 0);
      if (k % 3 == 1) begin
        checkOutput("fastRespAddr", respAddr2, fastAddr[k-1]);
        checkOutput("fastRespData", respData2, fastData[k-1]);
      end
    end
    reqValid2 = 1'b0;
    checkOutput("fastPulses", pulses, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/cpu_mem_ctrl.md
CPU_MEM_CTRL -- requirements
Module: CPU_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default `PHYSICAL_ADDR_WIDTH: physical byte-address width.
REQ-002 SHALL have parameter LINE_WIDTH, default 128: cache line width in bits, a power of two and at least 8.
REQ-003 SHALL have parameter DEPTH, default 256: number of line entries in the backing store, a power of two.
REQ-004 SHALL have parameter MEM_LATENCY, default 5: cycles from request acceptance to the response edge, at least 1.
REQ-005 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid, input, 1 bit: the cache presents a line request.
REQ-008 SHALL have port req_write, input, 1 bit: 1 is a line write-back, 0 is a line fill (read).
REQ-009 SHALL have port req_addr, input, ADDR_WIDTH bits: byte address of the line.
REQ-010 SHALL have port req_data, input, LINE_WIDTH bits: write-back line data.
REQ-011 SHALL have port available, output, 1 bit: the controller can accept a request this cycle; this drives the cache's mem_bus_available.
REQ-012 SHALL have port resp_valid, output, 1 bit: a one-cycle response pulse.
REQ-013 SHALL have port resp_addr, output, ADDR_WIDTH bits: req_addr of the completed request, echoed unchanged.
REQ-014 SHALL have port resp_data, output, LINE_WIDTH bits: fill data for a read, or the written line for a write.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY and RESPOND.
REQ-016 SHALL drive available=1 only in IDLE.
REQ-017 SHALL accept a request on a rising edge where state=IDLE and req_valid=1, latching req_write, req_addr and req_data.
REQ-018 SHALL, on acceptance, enter BUSY and load the latency counter with MEM_LATENCY-1.
REQ-019 SHALL ignore req_valid and all request inputs while not in IDLE: no queueing, no error indication.
REQ-020 SHALL, in BUSY, decrement the counter every cycle while it is nonzero.
REQ-021 SHALL, on the edge where the counter is 0 in BUSY, perform the store access and enter RESPOND.
REQ-022 SHALL form the store index as latched addr[OFF+log2(DEPTH)-1:OFF], with OFF=log2(LINE_WIDTH/8); offset bits and bits above the index are ignored, so aliased addresses wrap.
REQ-023 SHALL, on a write access, write the latched data to the indexed entry and load resp_data with that data.
REQ-024 SHALL, on a read access, load resp_data with the indexed entry as it stood before that edge.
REQ-025 SHALL hold resp_valid=1 for exactly the one RESPOND cycle, then return to IDLE on the next edge.
REQ-026 SHALL, for an acceptance at edge E0, have resp_valid high in the cycle after edge E0+MEM_LATENCY and available=1 again in the cycle after edge E0+MEM_LATENCY+1.
REQ-027 SHALL keep req_valid=1 during RESPOND from being accepted; it is accepted on the following IDLE edge instead.
REQ-028 SHALL hold resp_addr and resp_data stable from the RESPOND cycle until the next response is loaded.
REQ-029 SHALL make a read issued after a completed write to the same index return the written data.

Reset
REQ-030 SHALL, while reset=0, force state IDLE, counter 0, available=1, resp_valid=0, resp_addr=0 and resp_data=0, independent of clock.
REQ-031 SHALL, if reset is asserted mid-operation, abort the request with no response; a write not yet performed SHALL NOT modify the store.
REQ-032 SHALL leave backing-store contents unaffected by reset, and their power-up value undefined.
REQ-033 SHALL accept a request on the first rising edge after reset deasserts.

Verification
REQ-034 Defaults: write 0xA5A5_0000_1111_2222_3333_4444_5555_6666 at address 0x40, accepted at edge 0 -> available=0 after edge 0; resp_valid=1 only in the cycle after edge 5; available=1 after edge 6.
REQ-035 Read at 0x40 after REQ-034 -> resp_data=0xA5A5_0000_1111_2222_3333_4444_5555_6666, resp_addr=0x40.
REQ-036 Write 0x1 at address 0x40+DEPTH*16, then read 0x4F -> resp_data=0x1, showing index wrap and ignored offset bits.
REQ-037 Second req_valid during BUSY with a different address -> ignored: exactly one resp_valid pulse, and its resp_addr is the first request's address.
REQ-038 Assert reset 2 cycles after a write is accepted to 0x80, then read 0x80 -> no response for the aborted write; the read returns the prior contents of 0x80.
REQ-039 MEM_LATENCY=1, back-to-back requests with req_valid held high -> one acceptance every 3 cycles, each followed by a single resp_valid pulse.
